// File: rtl/pc_gen.sv
// pc_gen: program counter generator with redirect priority, fetch handshake and return-address stack
// Ports:
//   clk_i, rst_ni             clock (rising edge), asynchronous active-low reset
//   fetch_valid_o/ready_i     fetch handshake; addr_o is the current PC
//   step_half_i               accepted instruction is compressed (+2, C_EXT=1 only)
//   trap_i/mtvec_i            trap redirect and target
//   mret_i/mepc_i             trap-return redirect and target
//   jalr_i/alu_i              register-indirect redirect and target
//   branch_i/imm_i            PC-relative redirect and offset
//   ras_push_i/ras_pop_i      call / predicted return
//   ras_count_o               valid RAS entries
//   ras_underflow_o           one-cycle pulse after a pop on an empty RAS
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VALUE = XLEN'(32'h8000_0000),
  parameter int RAS_DEPTH = 4,
  parameter int C_EXT = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         fetch_valid_o,
  input  logic                         fetch_ready_i,
  output logic [XLEN-1:0]              addr_o,
  input  logic                         step_half_i,
  input  logic                         trap_i,
  input  logic [XLEN-1:0]              mtvec_i,
  input  logic                         mret_i,
  input  logic [XLEN-1:0]              mepc_i,
  input  logic                         jalr_i,
  input  logic [XLEN-1:0]              alu_i,
  input  logic                         branch_i,
  input  logic [XLEN-1:0]              imm_i,
  input  logic                         ras_push_i,
  input  logic                         ras_pop_i,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_underflow_o
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] MASK = (C_EXT != 0) ? ~XLEN'(1) : ~XLEN'(3);
  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;
  state_t state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, link, top, tgt;
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] ptr, ptr_nxt, ptr_top;
  logic [CW-1:0] cnt, cnt_nxt;
  logic fire, redir, push_w, wr_top, uf, uf_nxt;
  assign fetch_valid_o   = state == RUN;
  assign fire            = fetch_valid_o & fetch_ready_i;
  assign redir           = (state != BOOT) & (trap_i | mret_i | jalr_i | branch_i);
  assign link            = pc + ((C_EXT != 0 && step_half_i) ? XLEN'(2) : XLEN'(4));
  // ptr is the next free slot; the top of stack sits just below it
  assign ptr_top         = ptr - PW'(1);
  assign top             = ras[ptr_top];
  assign tgt             = (trap_i ? mtvec_i : mret_i ? mepc_i : jalr_i ? alu_i : pc + imm_i) & MASK;
  assign addr_o          = pc;
  assign ras_count_o     = cnt;
  assign ras_underflow_o = uf;
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    uf_nxt    = 1'b0;
    push_w    = 1'b0;
    wr_top    = 1'b0;
    if (state == BOOT) state_nxt = RUN;
    else if (redir) begin
      pc_nxt    = tgt;
      state_nxt = BUBBLE;
    end else if (state == BUBBLE) state_nxt = RUN;
    else if (fire) begin
      if (ras_pop_i && cnt != '0) begin
        pc_nxt    = top & MASK;
        state_nxt = BUBBLE;
        wr_top    = ras_push_i;
        if (!ras_push_i) begin
          ptr_nxt = ptr_top;
          cnt_nxt = cnt - CW'(1);
        end
      end else begin
        pc_nxt = link;
        uf_nxt = ras_pop_i;
        // when full, ptr already addresses the oldest entry, so a push overwrites it
        if (ras_push_i) begin
          push_w  = 1'b1;
          ptr_nxt = ptr + PW'(1);
          cnt_nxt = (cnt != CW'(RAS_DEPTH)) ? cnt + CW'(1) : cnt;
        end
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= BOOT;
      pc    <= RESET_VALUE & MASK;
      ptr   <= '0;
      cnt   <= '0;
      uf    <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      uf    <= uf_nxt;
    end
  end
  // stack contents survive reset; only pointer and count are cleared
  always_ff @(posedge clk_i) begin
    if (push_w) ras[ptr] <= link;
    else if (wr_top) ras[ptr_top] <= link;
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized check of pc_gen (C_EXT=1 and C_EXT=0) against a behavioural model
module tb_pc_gen;
  localparam int S_BOOT = 0, S_RUN = 1, S_BUB = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic ready, step_half, trap, mret, jalr, branch, push, pop;
  logic [31:0] mtvec, mepc, alu, imm;
  logic v0, v1, uf0, uf1;
  logic [31:0] a0, a1;
  logic [2:0] c0, c1;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m_pc [2];
  int m_st [2];
  logic [31:0] ms [2][4];
  int mn [2];
  logic m_uf [2];
  always #5 clk = ~clk;
  pc_gen #(.C_EXT(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .fetch_valid_o(v0), .fetch_ready_i(ready), .addr_o(a0),
    .step_half_i(step_half), .trap_i(trap), .mtvec_i(mtvec), .mret_i(mret), .mepc_i(mepc),
    .jalr_i(jalr), .alu_i(alu), .branch_i(branch), .imm_i(imm), .ras_push_i(push),
    .ras_pop_i(pop), .ras_count_o(c0), .ras_underflow_o(uf0));
  pc_gen #(.C_EXT(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .fetch_valid_o(v1), .fetch_ready_i(ready), .addr_o(a1),
    .step_half_i(step_half), .trap_i(trap), .mtvec_i(mtvec), .mret_i(mret), .mepc_i(mepc),
    .jalr_i(jalr), .alu_i(alu), .branch_i(branch), .imm_i(imm), .ras_push_i(push),
    .ras_pop_i(pop), .ras_count_o(c1), .ras_underflow_o(uf1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    ready = 0; step_half = 0; trap = 0; mret = 0; jalr = 0; branch = 0; push = 0; pop = 0;
    mtvec = 0; mepc = 0; alu = 0; imm = 0;
  endtask
  task automatic mreset(input int c);
    m_pc[c] = 32'h8000_0000; m_st[c] = S_BOOT; mn[c] = 0; m_uf[c] = 0;
  endtask
  // stack model: index 0 is the oldest entry, a push onto a full stack drops it
  task automatic model_step(input int c);
    logic [31:0] mask, link, nxt;
    bit ce;
    ce   = (c == 0);
    mask = ce ? ~32'h1 : ~32'h3;
    link = m_pc[c] + ((ce && step_half) ? 32'd2 : 32'd4);
    m_uf[c] = 0;
    if (m_st[c] == S_BOOT) m_st[c] = S_RUN;
    else if (trap || mret || jalr || branch) begin
      m_pc[c] = (trap ? mtvec : mret ? mepc : jalr ? alu : m_pc[c] + imm) & mask;
      m_st[c] = S_BUB;
    end else if (m_st[c] == S_BUB) m_st[c] = S_RUN;
    else if (ready) begin
      if (pop && mn[c] > 0) begin
        nxt = ms[c][mn[c]-1];
        if (push) ms[c][mn[c]-1] = link;
        else mn[c]--;
        m_pc[c] = nxt;
        m_st[c] = S_BUB;
      end else begin
        if (pop) m_uf[c] = 1;
        if (push) begin
          if (mn[c] == 4) begin
            for (int k = 0; k < 3; k++) ms[c][k] = ms[c][k+1];
            ms[c][3] = link;
          end else begin
            ms[c][mn[c]] = link;
            mn[c]++;
          end
        end
        m_pc[c] = link;
      end
    end
  endtask
  task automatic compare();
    chk("addr0", a0, m_pc[0]);
    chk("valid0", 32'(v0), 32'(m_st[0] == S_RUN));
    chk("cnt0", 32'(c0), 32'(mn[0]));
    chk("uf0", 32'(uf0), 32'(m_uf[0]));
    chk("addr1", a1, m_pc[1]);
    chk("valid1", 32'(v1), 32'(m_st[1] == S_RUN));
    chk("cnt1", 32'(c1), 32'(mn[1]));
    chk("uf1", 32'(uf1), 32'(m_uf[1]));
  endtask
  task automatic cyc();
    for (int c = 0; c < 2; c++) if (!rst_n) mreset(c); else model_step(c);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask
  initial begin
    idle();
    rst_n = 0;
    mreset(0); mreset(1);
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1; ready = 1;
    cyc();
    chk("boot_first", a0, 32'h8000_0000);
    chk("boot_valid", 32'(v0), 1);
    cyc();
    chk("boot_second", a0, 32'h8000_0004);
    cyc();
    chk("boot_third", a1, 32'h8000_0008);
    rst_n = 0;
    cyc();
    rst_n = 1;
    cyc();
    step_half = 1;
    cyc();
    chk("half_step_c1", a0, 32'h8000_0002);
    chk("half_step_c0", a1, 32'h8000_0004);
    step_half = 0; ready = 0;
    repeat (3) cyc();
    chk("stall_hold", a0, 32'h8000_0002);
    idle();
    trap = 1; jalr = 1; branch = 1; mtvec = 32'h103; alu = 32'h555; imm = 32'h40;
    cyc();
    chk("prio_c1", a0, 32'h102);
    chk("prio_c0", a1, 32'h100);
    chk("prio_bubble", 32'(v0), 0);
    idle(); ready = 1;
    cyc();
    chk("prio_run", 32'(v0), 1);
    for (int k = 1; k <= 5; k++) begin
      idle(); jalr = 1; alu = 32'(k * 16);
      cyc();
      idle(); ready = 1; push = 1;
      cyc();
      cyc();
    end
    chk("ras_full", 32'(c0), 4);
    for (int k = 0; k < 4; k++) begin
      idle(); ready = 1; pop = 1;
      cyc();
      chk("ras_pop", a0, 32'(32'h54 - k * 16));
      idle(); ready = 1;
      cyc();
    end
    chk("ras_empty", 32'(c0), 0);
    pop = 1;
    cyc();
    chk("underflow_pulse", 32'(uf0), 1);
    chk("underflow_seq", a0, 32'h28);
    idle(); ready = 1;
    cyc();
    chk("underflow_clear", 32'(uf0), 0);
    idle(); jalr = 1; alu = 32'hFFFF_FFFC;
    cyc();
    idle(); ready = 1;
    cyc();
    cyc();
    chk("wrap_c0", a1, 32'h0);
    chk("wrap_c1", a0, 32'h0);
    cyc();
    branch = 1; imm = 32'hFFFF_FFF8;
    cyc();
    chk("branch_wrap", a1, 32'hFFFF_FFFC);
    idle(); ready = 1;
    cyc();
    push = 1;
    cyc();
    idle();
    cyc();
    chk("stall_cnt", 32'(c0), 1);
    rst_n = 0;
    #1;
    chk("rst_addr", a0, 32'h8000_0000);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_cnt", 32'(c1), 0);
    mreset(0); mreset(1);
    @(negedge clk);
    compare();
    rst_n = 1; ready = 1;
    cyc();
    chk("rst_first_fire", a1, 32'h8000_0000);
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      ready     = ($urandom_range(0, 3) != 0);
      step_half = 1'($urandom_range(0, 1));
      trap      = ($urandom_range(0, 29) == 0);
      mret      = ($urandom_range(0, 29) == 0);
      jalr      = ($urandom_range(0, 19) == 0);
      branch    = ($urandom_range(0, 19) == 0);
      mtvec     = $urandom;
      mepc      = $urandom;
      alu       = $urandom;
      imm       = $urandom_range(0, 511) - 32'd256;
      push      = ($urandom_range(0, 2) == 0);
      pop       = ($urandom_range(0, 2) == 0);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
